ctrl_sequencer: RTL and testbench

Hardwired control sequencer that drives the datapath control strobes once a testbench no longer has to sequence them by hand. It runs the common fetch steps (T0–T2), decodes the latched instruction, and issues execute steps for register-to-register ALU, multiply/divide, unary, nop and halt instructions. It sits beside `Datapath`: it reads the IR contents and drives the same-named control inputs.

---
 rtl/ctrl_pkg.sv | 64 ++++++
 rtl/reg_select.sv | 16 +
 rtl/ctrl_sequencer.sv | 175 +++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: states, IR opcodes, field slices.
// No logic of its own; alu_op and the opcode class predicates are pure combinational helpers.
// Not applicable: holds declarations only, with no handshakes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_HALTED = 4'd8
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_NOP = 5'b01101;
    localparam logic [4:0] ALU_AND = 5'b00000;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    // The ALU encodes AND as zero; every other operation shares the IR opcode value.
    function automatic logic [4:0] alu_op(input logic [4:0] op);
        return (op == OP_AND) ? ALU_AND : op;
    endfunction

    function automatic logic is_three_op(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
                          OP_ROL, OP_SHR, OP_SHRA, OP_SHL};
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/reg_select.sv
// 4-bit register index to one-hot enable decoder, gated by en.
// Purely combinational, zero latency.
// No flow control; indices at or beyond NREGS decode to all zeros.
module reg_select #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       sel,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    for (genvar i = 0; i < NREGS; i++) begin : g_dec
        assign onehot[i] = en && (int'(sel) == i);
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the datapath control strobes.
// Strobes are a Moore decode of state and IR; 4-7 clocks per instruction from T0.
// No backpressure: one T-state per clock; only clear leaves HALTED.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [31:0]      IR,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic [4:0]       opcode,
    output logic             run,
    output logic             illegal
);

    state_t     state;
    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       three_op;
    logic       muldiv;
    logic       unary;
    logic       rin_en;
    logic       rout_en;
    logic [3:0] rout_sel;
    logic       unused_ir_bits;

    assign op       = IR[OP_MSB:OP_LSB];
    assign ra       = IR[RA_MSB:RA_LSB];
    assign rb       = IR[RB_MSB:RB_LSB];
    assign rc       = IR[RC_MSB:RC_LSB];
    assign three_op = is_three_op(op);
    assign muldiv   = is_muldiv(op);
    assign unary    = is_unary(op);
    assign unused_ir_bits = ^IR[RC_LSB-1:0];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state <= start ? ST_T0 : ST_IDLE;
                ST_T0:     state <= ST_T1;
                ST_T1:     state <= ST_T2;
                ST_T2:     state <= ST_T3;
                ST_T3: begin
                    if (three_op || muldiv || unary)
                        state <= ST_T4;
                    else if (op == OP_HALT)
                        state <= ST_HALTED;
                    else
                        state <= ST_T0;
                end
                ST_T4:     state <= (three_op || muldiv) ? ST_T5 : ST_T0;
                ST_T5:     state <= muldiv ? ST_T6 : ST_T0;
                ST_T6:     state <= ST_T0;
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        opcode   = ALU_NOP;
        illegal  = 1'b0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rout_sel = rb;
        run      = (state != ST_IDLE) && (state != ST_HALTED);

        case (state)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                if (three_op || muldiv) begin
                    rout_en = 1'b1;
                    Yin     = 1'b1;
                end else if (unary) begin
                    rout_en = 1'b1;
                    Zin     = 1'b1;
                    opcode  = alu_op(op);
                end else if (op != OP_NOP && op != OP_HALT) begin
                    illegal = 1'b1;
                end
            end
            ST_T4: begin
                if (three_op || muldiv) begin
                    rout_en  = 1'b1;
                    rout_sel = rc;
                    Zin      = 1'b1;
                    opcode   = alu_op(op);
                end else if (unary) begin
                    Zlowout = 1'b1;
                    rin_en  = 1'b1;
                end
            end
            ST_T5: begin
                if (three_op) begin
                    Zlowout = 1'b1;
                    rin_en  = 1'b1;
                end else if (muldiv) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
            end
            ST_T6: begin
                if (muldiv) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    reg_select #(.NREGS(NREGS)) u_rin_sel (
        .sel    (ra),
        .en     (rin_en),
        .onehot (Rin)
    );

    reg_select #(.NREGS(NREGS)) u_rout_sel (
        .sel    (rout_sel),
        .en     (rout_en),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: fetch, ALU/muldiv/unary/nop/illegal execute, halt, async clear.
module tb_ctrl_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [31:0] IR    = 32'h0;
    logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic Yin, Zin, Zlowout, Zhighout, HIin, LOin, run, illegal;
    logic [15:0] Rin, Rout;
    logic [4:0]  opcode;
    logic [15:0] strb;

    int checks   = 0;
    int failures = 0;

    localparam logic [15:0] B_PCOUT  = 16'h8000;
    localparam logic [15:0] B_PCIN   = 16'h4000;
    localparam logic [15:0] B_INCPC  = 16'h2000;
    localparam logic [15:0] B_MARIN  = 16'h1000;
    localparam logic [15:0] B_READ   = 16'h0800;
    localparam logic [15:0] B_MDRIN  = 16'h0400;
    localparam logic [15:0] B_MDROUT = 16'h0200;
    localparam logic [15:0] B_IRIN   = 16'h0100;
    localparam logic [15:0] B_YIN    = 16'h0080;
    localparam logic [15:0] B_ZIN    = 16'h0040;
    localparam logic [15:0] B_ZLOW   = 16'h0020;
    localparam logic [15:0] B_ZHIGH  = 16'h0010;
    localparam logic [15:0] B_HIIN   = 16'h0008;
    localparam logic [15:0] B_LOIN   = 16'h0004;
    localparam logic [15:0] B_RUN    = 16'h0002;
    localparam logic [15:0] B_ILL    = 16'h0001;

    localparam logic [15:0] S_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
    localparam logic [15:0] S_T1 = B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
    localparam logic [15:0] S_T2 = B_MDROUT | B_IRIN | B_RUN;
    localparam logic [4:0]  NOP  = 5'b01101;

    assign strb = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                   Yin, Zin, Zlowout, Zhighout, HIin, LOin, run, illegal};

    ctrl_sequencer #(.NREGS(16)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .IR       (IR),
        .PCout    (PCout),
        .PCin     (PCin),
        .IncPC    (IncPC),
        .MARin    (MARin),
        .Read     (Read),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .IRin     (IRin),
        .Yin      (Yin),
        .Zin      (Zin),
        .Zlowout  (Zlowout),
        .Zhighout (Zhighout),
        .HIin     (HIin),
        .LOin     (LOin),
        .Rin      (Rin),
        .Rout     (Rout),
        .opcode   (opcode),
        .run      (run),
        .illegal  (illegal)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [15:0] s,
                              input logic [15:0] rin_e, input logic [15:0] rout_e,
                              input logic [4:0] opc_e);
        check({tag, ".strb"},   {16'h0, strb},   {16'h0, s});
        check({tag, ".Rin"},    {16'h0, Rin},    {16'h0, rin_e});
        check({tag, ".Rout"},   {16'h0, Rout},   {16'h0, rout_e});
        check({tag, ".opcode"}, {27'h0, opcode}, {27'h0, opc_e});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Entered with the DUT in T0; leaves it in T3.
    task automatic fetch(input string tag);
        expect_all({tag, ".T0"}, S_T0, 16'h0, 16'h0, NOP);
        step();
        expect_all({tag, ".T1"}, S_T1, 16'h0, 16'h0, NOP);
        step();
        expect_all({tag, ".T2"}, S_T2, 16'h0, 16'h0, NOP);
        step();
    endtask

    initial begin
        #2 clear = 1'b1;
        #1;
        expect_all("reset", 16'h0, 16'h0, 16'h0, NOP);
        step();
        step();
        clear = 1'b0;
        step();
        expect_all("idle_no_start", 16'h0, 16'h0, 16'h0, NOP);

        // and R1,R2,R3
        IR    = 32'h28918000;
        start = 1'b1;
        step();
        start = 1'b0;
        fetch("and");
        expect_all("and.T3", B_YIN | B_RUN, 16'h0, 16'h0004, NOP);
        step();
        expect_all("and.T4", B_ZIN | B_RUN, 16'h0, 16'h0008, 5'b00000);
        step();
        expect_all("and.T5", B_ZLOW | B_RUN, 16'h0002, 16'h0, NOP);
        step();

        // mul R6,R7
        IR = 32'h80338000;
        fetch("mul");
        expect_all("mul.T3", B_YIN | B_RUN, 16'h0, 16'h0040, NOP);
        step();
        expect_all("mul.T4", B_ZIN | B_RUN, 16'h0, 16'h0080, 5'b10000);
        step();
        expect_all("mul.T5", B_ZLOW | B_LOIN | B_RUN, 16'h0, 16'h0, NOP);
        step();
        expect_all("mul.T6", B_ZHIGH | B_HIIN | B_RUN, 16'h0, 16'h0, NOP);
        step();

        // neg R5,R9
        IR = 32'h8AC80000;
        fetch("neg");
        expect_all("neg.T3", B_ZIN | B_RUN, 16'h0, 16'h0200, 5'b10001);
        step();
        expect_all("neg.T4", B_ZLOW | B_RUN, 16'h0020, 16'h0, NOP);
        step();

        // undefined opcode 11111
        IR = 32'hF8000000;
        fetch("ill");
        expect_all("ill.T3", B_ILL | B_RUN, 16'h0, 16'h0, NOP);
        step();

        // nop
        IR = 32'hD0000000;
        fetch("nop");
        expect_all("nop.T3", B_RUN, 16'h0, 16'h0, NOP);
        step();

        // add R1,R2,R3 aborted by clear during T4
        IR = 32'h18918000;
        fetch("add");
        expect_all("add.T3", B_YIN | B_RUN, 16'h0, 16'h0004, NOP);
        step();
        expect_all("add.T4", B_ZIN | B_RUN, 16'h0, 16'h0008, 5'b00011);
        #2 clear = 1'b1;
        #1;
        expect_all("clr_async", 16'h0, 16'h0, 16'h0, NOP);
        step();
        clear = 1'b0;
        step();
        expect_all("clr_idle", 16'h0, 16'h0, 16'h0, NOP);

        // halt with start held high throughout
        IR    = 32'hD8000000;
        start = 1'b1;
        step();
        fetch("halt");
        expect_all("halt.T3", B_RUN, 16'h0, 16'h0, NOP);
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("halted%0d.strb", i), {16'h0, strb}, 32'h0);
            check($sformatf("halted%0d.opcode", i), {27'h0, opcode}, {27'h0, NOP});
        end
        #1 clear = 1'b1;
        #2;
        expect_all("halt_clr", 16'h0, 16'h0, 16'h0, NOP);
        clear = 1'b0;
        step();
        expect_all("restart.T0", S_T0, 16'h0, 16'h0, NOP);
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
